// File: rtl/counter_run_arbiter.sv
// Round-robin scheduler that lends one shared up-counter to NREQ requesters.
// Each granted requester runs the counter from 0 to its clamped limit.
module counter_run_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  limit,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       count,
    output logic                   busy
);

    localparam int unsigned        PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0]   MAX_LIM = WIDTH'(MAX_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [WIDTH-1:0]  lim_q, lim_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              busy_q, busy_d;

    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;
    logic [WIDTH-1:0]  pick_raw;
    logic [WIDTH-1:0]  pick_lim;
    logic [PW-1:0]     owner_nxt;

    // First set request searching upward from the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Limit is clamped to the ceiling so the counter can never wrap.
    always_comb begin
        pick_raw = limit[32'(pick_idx)*WIDTH +: WIDTH];
        pick_lim = (32'(pick_raw) > MAX_VALUE) ? MAX_LIM : pick_raw;
    end

    assign owner_nxt = PW'((32'(owner_q) + 32'd1) % NREQ);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lim_d   = lim_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d   = '0;
                count_d = '0;
                if (pick_vld) begin
                    owner_d = pick_idx;
                    lim_d   = pick_lim;
                    gnt_d   = NREQ'(1) << pick_idx;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks terminal so a dropped request never sees done.
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    count_d = '0;
                    ptr_d   = owner_nxt;
                    state_d = ST_IDLE;
                end else if (count_q == lim_q) begin
                    gnt_d   = '0;
                    count_d = '0;
                    done_d  = NREQ'(1) << owner_q;
                    ptr_d   = owner_nxt;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lim_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lim_q   <= lim_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed self-checking bench for counter_run_arbiter with hand-computed expectations.
module tb_counter_run_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] limit;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  count;
    logic        busy;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned maxc;

    counter_run_arbiter #(
        .NREQ      (4),
        .WIDTH     (4),
        .MAX_VALUE (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .limit (limit),
        .gnt   (gnt),
        .done  (done),
        .count (count),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        limit = '0;
        #12;
        check_val("rst_gnt",   32'(gnt),   32'h0);
        check_val("rst_done",  32'(done),  32'h0);
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_busy",  32'(busy),  32'h0);
        reset = 1'b0;
        tick();
        check_val("idle_busy", 32'(busy), 32'h0);

        // Single requester, limit 3
        limit[3:0] = 4'd3;
        req        = 4'b0001;
        tick();
        check_val("s1_gnt0",  32'(gnt),   32'h1);
        check_val("s1_cnt0",  32'(count), 32'h0);
        check_val("s1_busy",  32'(busy),  32'h1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_val("s1_gnt",  32'(gnt),   32'h1);
            check_val("s1_cnt",  32'(count), 32'(c));
        end
        tick();
        check_val("s1_gnt_off", 32'(gnt),   32'h0);
        check_val("s1_done",    32'(done),  32'h1);
        check_val("s1_cnt_clr", 32'(count), 32'h0);
        check_val("s1_busy_dn", 32'(busy),  32'h1);
        req = 4'b0000;
        tick();
        check_val("s1_done_off", 32'(done), 32'h0);
        check_val("s1_busy_lo",  32'(busy), 32'h0);
        tick();
        check_val("s1_busy_lo2", 32'(busy), 32'h0);
        check_val("s1_idle_gnt", 32'(gnt),  32'h0);

        // All requesting, limits 1: rotation 0,1,2,3,0
        pulse_reset();
        limit = 16'h1111;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("rr_gnt_a", 32'(gnt),   32'(4'b0001 << (k % 4)));
            check_val("rr_cnt_a", 32'(count), 32'h0);
            tick();
            check_val("rr_gnt_b", 32'(gnt),   32'(4'b0001 << (k % 4)));
            check_val("rr_cnt_b", 32'(count), 32'h1);
            tick();
            check_val("rr_gnt_off", 32'(gnt),  32'h0);
            check_val("rr_done",    32'(done), 32'(4'b0001 << (k % 4)));
            tick();
            check_val("rr_idle_done", 32'(done), 32'h0);
            check_val("rr_idle_gnt",  32'(gnt),  32'h0);
        end
        req = 4'b0000;
        tick();

        // Clamp: limit 12 runs to 8 only
        pulse_reset();
        limit        = '0;
        limit[11:8]  = 4'd12;
        req          = 4'b0100;
        maxc         = 0;
        for (int c = 0; c <= 8; c++) begin
            tick();
            check_val("cl_gnt", 32'(gnt),   32'h4);
            check_val("cl_cnt", 32'(count), 32'(c));
            if (32'(count) > maxc) maxc = 32'(count);
        end
        tick();
        check_val("cl_gnt_off", 32'(gnt),   32'h0);
        check_val("cl_done",    32'(done),  32'h4);
        check_val("cl_cnt_clr", 32'(count), 32'h0);
        check_val("cl_max",     maxc,       32'd8);
        req = 4'b0000;
        tick();

        // Zero limit completes on first RUN edge
        limit[7:4] = 4'd0;
        req        = 4'b0010;
        tick();
        check_val("z_gnt", 32'(gnt),   32'h2);
        check_val("z_cnt", 32'(count), 32'h0);
        tick();
        check_val("z_gnt_off", 32'(gnt),   32'h0);
        check_val("z_done",    32'(done),  32'h2);
        check_val("z_cnt_off", 32'(count), 32'h0);
        req = 4'b0000;
        tick();
        check_val("z_done_off", 32'(done), 32'h0);

        // Abort at count 2 with req[1] pending
        pulse_reset();
        limit      = '0;
        limit[3:0] = 4'd6;
        req        = 4'b0011;
        tick();
        check_val("ab_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        check_val("ab_cnt2", 32'(count), 32'h2);
        req = 4'b0010;
        tick();
        check_val("ab_gnt_off", 32'(gnt),   32'h0);
        check_val("ab_cnt_clr", 32'(count), 32'h0);
        check_val("ab_no_done", 32'(done),  32'h0);
        check_val("ab_busy",    32'(busy),  32'h0);
        tick();
        check_val("ab_next_gnt", 32'(gnt),   32'h2);
        check_val("ab_next_cnt", 32'(count), 32'h0);
        req = 4'b0000;
        tick();
        check_val("ab2_gnt",  32'(gnt),  32'h0);
        check_val("ab2_done", 32'(done), 32'h0);
        tick();

        // Async reset during RUN at count 5
        limit[15:12] = 4'd7;
        req          = 4'b1000;
        tick();
        check_val("ar_gnt", 32'(gnt), 32'h8);
        for (int c = 1; c <= 5; c++) tick();
        check_val("ar_cnt5", 32'(count), 32'h5);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_gnt0",  32'(gnt),   32'h0);
        check_val("ar_done0", 32'(done),  32'h0);
        check_val("ar_cnt0",  32'(count), 32'h0);
        check_val("ar_busy0", 32'(busy),  32'h0);
        #1;
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        check_val("ar_ptr0_gnt", 32'(gnt),   32'h1);
        check_val("ar_ptr0_cnt", 32'(count), 32'h0);
        req = 4'b1000;
        tick();
        check_val("ar_ab_gnt",  32'(gnt),  32'h0);
        check_val("ar_ab_done", 32'(done), 32'h0);
        tick();
        check_val("ar_r3_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        check_val("ar_r3_off", 32'(gnt), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
